// File: rtl/step_gen_pkg.sv
// Shared encodings for the step pulse generator: FSM states, timing width
// and the "zero means one" clamp used for every timed phase.
package step_gen_pkg;

    localparam int TW = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    function automatic logic [TW-1:0] clamp1(input logic [TW-1:0] v);
        return (v == '0) ? TW'(1) : v;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW phases.
// done is high in the last cycle of a loaded duration of 'value' cycles.
module pulse_timer
    import step_gen_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          done
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - TW'(1);
    end

    assign done = (cnt == TW'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// Turns step request strobes into STEP/DIR pulse trains with guaranteed
// width, gap and DIR setup. Optional position counter: STEP_PULSE_GEN_POSITION_EN.
module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int PEND_W       = 8,
    parameter int SETUP_CYCLES = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              dir_in,
    input  logic [15:0]       high_cycles,
    input  logic [15:0]       low_cycles,
    output logic              step,
    output logic              dir,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              drop
`ifdef STEP_PULSE_GEN_POSITION_EN
   ,output logic [31:0]       position
`endif
);

    localparam logic [TW-1:0] SETUP_LD = TW'((SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES);

    logic [1:0]        state, state_n;
    logic              qdir, dir_n;
    logic              start, dec, ld, done;
    logic [TW-1:0]     ld_val;
    logic              pend_nz, pend_full, acc;
    logic [PEND_W-1:0] pending_n;

    pulse_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld),
        .value (ld_val),
        .done  (done)
    );

    assign pend_nz   = (pending != '0);
    assign pend_full = &pending;
    // Fullness and direction checks use the pre-cycle queue state.
    assign acc       = req && !pend_full && (!pend_nz || (dir_in == qdir));
    assign pending_n = pending + PEND_W'(acc) - PEND_W'(dec);

    always_comb begin
        state_n = state;
        dir_n   = dir;
        start   = 1'b0;
        dec     = 1'b0;
        ld      = 1'b0;
        ld_val  = '0;
        case (state)
            ST_IDLE:  start = pend_nz;
            ST_SETUP: if (done) begin
                state_n = ST_HIGH;
                dec     = 1'b1;
                ld      = 1'b1;
                ld_val  = clamp1(high_cycles);
            end
            ST_HIGH:  if (done) begin
                state_n = ST_LOW;
                ld      = 1'b1;
                ld_val  = clamp1(low_cycles);
            end
            default:  if (done) begin
                if (pend_nz) start   = 1'b1;
                else         state_n = ST_IDLE;
            end
        endcase
        // End of LOW falls straight into the start decision, no IDLE bubble.
        if (start) begin
            ld = 1'b1;
            if (dir != qdir) begin
                state_n = ST_SETUP;
                dir_n   = qdir;
                ld_val  = SETUP_LD;
            end else begin
                state_n = ST_HIGH;
                dec     = 1'b1;
                ld_val  = clamp1(high_cycles);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            dir     <= 1'b0;
            qdir    <= 1'b0;
            pending <= '0;
            drop    <= 1'b0;
            step    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            dir     <= dir_n;
            pending <= pending_n;
            drop    <= req && !acc;
            step    <= (state_n == ST_HIGH);
            busy    <= (state_n != ST_IDLE) || (pending_n != '0);
            if (acc && !pend_nz)
                qdir <= dir_in;
        end
    end

`ifdef STEP_PULSE_GEN_POSITION_EN
    // dir already equals the queued direction whenever HIGH is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            position <= '0;
        else if (dec)
            position <= dir ? position + 32'd1 : position - 32'd1;
    end
`endif

endmodule
